ascon_stream_feeder: RTL and testbench

ASCON_STREAM_FEEDER -- requirements
Module: ascon_stream_feeder

---
 rtl/ascon_stream_feeder.sv | 190 +++++++++++++++++++
 tb/tb_ascon_stream_feeder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_stream_feeder.sv
// Stream adapter between a host word/ciphertext interface and an ASCON AEAD core.
// Optional tag comparison is built when ASCON_TAG_CHECK_EN is defined.
module ascon_stream_feeder (
  input  logic          clk,
  input  logic          nRST,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_mode,
  output logic          cmd_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic [3:0]    in_len,
  input  logic          in_last,
  output logic          core_start,
  output logic [1:0]    core_mode,
  output logic [63:0]   core_blockin,
  output logic [3:0]    core_datalen,
  input  logic          core_read,
  input  logic [63:0]   core_CTblock,
  input  logic          core_CTv,
  input  logic [127:0]  core_Tag,
  input  logic          core_Tv,
  output logic          ct_valid,
  input  logic          ct_ready,
  output logic [63:0]   ct_data,
  output logic          tag_valid,
  output logic [127:0]  tag_out,
  output logic          busy,
  output logic          err_underrun,
  output logic          err_overflow
`ifdef ASCON_TAG_CHECK_EN
  ,
  input  logic [127:0]  exp_tag,
  output logic          tag_ok
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_PAD, S_WAIT_TAG} state_t;

  state_t         state_q, state_d;
  logic [63:0]    in_data_q [4];
  logic [3:0]     in_len_q  [4];
  logic           in_last_q [4];
  logic [1:0]     in_wr_q, in_rd_q;
  logic [2:0]     in_cnt_q;
  logic           last_seen_q;
  logic [63:0]    ct_mem_q [4];
  logic [1:0]     ct_wr_q, ct_rd_q;
  logic [2:0]     ct_cnt_q;
  logic           core_start_q, tag_valid_q, err_underrun_q, err_overflow_q;
  logic [1:0]     core_mode_q;
  logic [127:0]   tag_out_q;
`ifdef ASCON_TAG_CHECK_EN
  logic [127:0]   exp_tag_q;
  logic           tag_ok_q;
`endif

  logic in_empty, in_push, in_pop, underrun, cmd_accept;
  logic ct_pop, ct_push, ct_drop, tag_take;
  logic [3:0] in_len_clamped;

  assign in_empty       = (in_cnt_q == 3'd0);
  assign in_ready       = (in_cnt_q != 3'd4) && !last_seen_q &&
                          (state_q == S_START || state_q == S_FEED);
  assign in_push        = in_valid && in_ready;
  assign in_pop         = core_read && !in_empty;
  assign underrun       = core_read && in_empty && (state_q == S_FEED);
  assign in_len_clamped = (in_len > 4'd8) ? 4'd8 : in_len;
  assign cmd_accept     = (state_q == S_IDLE) && cmd_valid;
  assign ct_pop         = ct_valid && ct_ready;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign ct_push        = core_CTv && ((ct_cnt_q != 3'd4) || ct_pop);
  assign ct_drop        = core_CTv && !ct_push;
  assign tag_take       = (state_q == S_WAIT_TAG) && core_Tv;

  assign core_blockin = in_empty ? 64'd0 : in_data_q[in_rd_q];
  assign core_datalen = in_empty ? 4'd0  : in_len_q[in_rd_q];
  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign core_start   = core_start_q;
  assign core_mode    = core_mode_q;
  assign ct_valid     = (ct_cnt_q != 3'd0);
  assign ct_data      = ct_mem_q[ct_rd_q];
  assign tag_valid    = tag_valid_q;
  assign tag_out      = tag_out_q;
  assign err_underrun = err_underrun_q;
  assign err_overflow = err_overflow_q;
`ifdef ASCON_TAG_CHECK_EN
  assign tag_ok       = tag_ok_q;
`endif

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cmd_valid) state_d = S_START;
      S_START:    state_d = S_FEED;
      S_FEED:     if (in_pop && in_last_q[in_rd_q])
                    state_d = (in_len_q[in_rd_q] == 4'd8) ? S_PAD : S_WAIT_TAG;
      S_PAD:      if (core_read) state_d = S_WAIT_TAG;
      S_WAIT_TAG: if (core_Tv) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q        <= S_IDLE;
      in_wr_q        <= '0;
      in_rd_q        <= '0;
      in_cnt_q       <= '0;
      last_seen_q    <= 1'b0;
      ct_wr_q        <= '0;
      ct_rd_q        <= '0;
      ct_cnt_q       <= '0;
      core_start_q   <= 1'b0;
      core_mode_q    <= '0;
      tag_valid_q    <= 1'b0;
      tag_out_q      <= '0;
      err_underrun_q <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
      exp_tag_q      <= '0;
      tag_ok_q       <= 1'b0;
`endif
      // NOTE: FIFO storage is cleared on reset so no stale block can reach the core or host.
      for (int i = 0; i < 4; i++) begin
        in_data_q[i] <= '0;
        in_len_q[i]  <= '0;
        in_last_q[i] <= 1'b0;
        ct_mem_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      core_start_q <= cmd_accept;
      if (cmd_accept) begin
        core_mode_q <= cmd_mode;
        last_seen_q <= 1'b0;
      end

      if (in_push) begin
        in_data_q[in_wr_q] <= in_data;
        in_len_q[in_wr_q]  <= in_len_clamped;
        in_last_q[in_wr_q] <= in_last;
        in_wr_q            <= in_wr_q + 2'd1;
        if (in_last) last_seen_q <= 1'b1;
      end
      if (in_pop) in_rd_q <= in_rd_q + 2'd1;
      case ({in_push, in_pop})
        2'b10:   in_cnt_q <= in_cnt_q + 3'd1;
        2'b01:   in_cnt_q <= in_cnt_q - 3'd1;
        default: in_cnt_q <= in_cnt_q;
      endcase

      if (ct_push) begin
        ct_mem_q[ct_wr_q] <= core_CTblock;
        ct_wr_q           <= ct_wr_q + 2'd1;
      end
      if (ct_pop) ct_rd_q <= ct_rd_q + 2'd1;
      case ({ct_push, ct_pop})
        2'b10:   ct_cnt_q <= ct_cnt_q + 3'd1;
        2'b01:   ct_cnt_q <= ct_cnt_q - 3'd1;
        default: ct_cnt_q <= ct_cnt_q;
      endcase

      if (cmd_accept) begin
        tag_valid_q <= 1'b0;
      end else if (tag_take) begin
        tag_valid_q <= 1'b1;
        tag_out_q   <= core_Tag;
      end
`ifdef ASCON_TAG_CHECK_EN
      if (cmd_accept) begin
        exp_tag_q <= exp_tag;
        tag_ok_q  <= 1'b0;
      end else if (tag_take) begin
        tag_ok_q  <= (core_Tag == exp_tag_q);
      end
`endif

      if (cmd_accept)    err_underrun_q <= 1'b0;
      else if (underrun) err_underrun_q <= 1'b1;
      // A drop in the accept cycle still belongs to the host's view, so it wins over the clear.
      if (ct_drop)         err_overflow_q <= 1'b1;
      else if (cmd_accept) err_overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_stream_feeder.sv
// Scoreboard bench for ascon_stream_feeder: drivers queue expected core reads,
// ciphertext blocks and tags; independent monitors compare whenever the DUT presents them.
module tb_ascon_stream_feeder;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  len;
  } blk_t;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_mode = '0;
  logic          cmd_ready;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic [3:0]    in_len = '0;
  logic          in_last = 1'b0;
  logic          core_start;
  logic [1:0]    core_mode;
  logic [63:0]   core_blockin;
  logic [3:0]    core_datalen;
  logic          core_read = 1'b0;
  logic [63:0]   core_CTblock = '0;
  logic          core_CTv = 1'b0;
  logic [127:0]  core_Tag = '0;
  logic          core_Tv = 1'b0;
  logic          ct_valid;
  logic          ct_ready = 1'b0;
  logic [63:0]   ct_data;
  logic          tag_valid;
  logic [127:0]  tag_out;
  logic          busy, err_underrun, err_overflow;
`ifdef ASCON_TAG_CHECK_EN
  logic [127:0]  exp_tag = '0;
  logic          tag_ok;
`endif

  ascon_stream_feeder dut (
    .clk(clk), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len), .in_last(in_last),
    .core_start(core_start), .core_mode(core_mode), .core_blockin(core_blockin),
    .core_datalen(core_datalen), .core_read(core_read),
    .core_CTblock(core_CTblock), .core_CTv(core_CTv), .core_Tag(core_Tag), .core_Tv(core_Tv),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .tag_valid(tag_valid), .tag_out(tag_out),
    .busy(busy), .err_underrun(err_underrun), .err_overflow(err_overflow)
`ifdef ASCON_TAG_CHECK_EN
    , .exp_tag(exp_tag), .tag_ok(tag_ok)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the core should see, what the host should receive.
  blk_t          core_exp[$];
  logic [63:0]   ct_exp[$];
  logic [63:0]   ct_model[$];
  logic [127:0]  tag_exp[$];
  int            in_cnt = 0;
  int            last_len = 0;
  bit            exp_ovf = 1'b0;
  logic          tv_prev = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitors: compare whenever the DUT presents a transfer.
  always @(negedge clk) begin
    if (nRST && core_read) begin
      if (core_exp.size() == 0) begin
        check("core_read_unexpected", 1, 0);
      end else begin
        blk_t e;
        e = core_exp.pop_front();
        check("core_blockin", core_blockin, e.data);
        check("core_datalen", core_datalen, e.len);
      end
    end
  end

  always @(negedge clk) begin
    if (nRST && ct_valid && ct_ready) begin
      if (ct_exp.size() == 0) check("ct_unexpected", 1, 0);
      else check("ct_data", ct_data, ct_exp.pop_front());
    end
  end

  always @(negedge clk) begin
    if (nRST && tag_valid && !tv_prev) begin
      if (tag_exp.size() == 0) check("tag_unexpected", 1, 0);
      else check("tag_out", tag_out, tag_exp.pop_front());
    end
    tv_prev <= tag_valid;
  end

  task automatic start_cmd(input logic [1:0] mode);
    check("cmd_ready_before", cmd_ready, 1);
    cmd_mode  = mode;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_ovf   = 1'b0;
    check("core_start_pulse", core_start, 1);
    check("busy_after_cmd", busy, 1);
    check("core_mode", core_mode, mode);
    check("tag_valid_cleared", tag_valid, 0);
    tick();
    check("core_start_single", core_start, 0);
  endtask

  task automatic push_word(input logic [63:0] d, input int len, input bit last);
    bit ok = 1'b0;
    int cl;
    in_data  = d;
    in_len   = len[3:0];
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("in_accept", ok, 1);
    if (ok) begin
      cl = (len > 8) ? 8 : len;
      core_exp.push_back({d, cl[3:0]});
      in_cnt++;
      last_len = cl;
    end
  endtask

  task automatic core_rd();
    core_read = 1'b1;
    tick();
    core_read = 1'b0;
    if (in_cnt > 0) in_cnt--;
  endtask

  // A read while no word is queued (padding, underrun) must present 0/0.
  task automatic core_rd_empty();
    core_exp.push_back('0);
    core_rd();
  endtask

  task automatic send_tag(input logic [127:0] t);
    tag_exp.push_back(t);
    core_Tag = t;
    core_Tv  = 1'b1;
    tick();
    core_Tv  = 1'b0;
    check("tag_valid_set", tag_valid, 1);
    check("idle_after_tag", busy, 0);
  endtask

  task automatic ct_cycle(input bit push, input logic [63:0] blk, input bit rdy);
    bit pop, acc;
    pop = rdy && (ct_model.size() > 0);
    acc = push && ((ct_model.size() < 4) || pop);
    if (pop) void'(ct_model.pop_front());
    if (acc) begin
      ct_model.push_back(blk);
      ct_exp.push_back(blk);
    end else if (push) begin
      exp_ovf = 1'b1;
    end
    core_CTv     = push;
    core_CTblock = blk;
    ct_ready     = rdy;
    tick();
    core_CTv = 1'b0;
    ct_ready = 1'b0;
  endtask

  task automatic ct_drain();
    for (int i = 0; i < 10 && ct_model.size() > 0; i++) ct_cycle(1'b0, '0, 1'b1);
    check("ct_drained", ct_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t;
    tick();
    tick();
    nRST = 1'b1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ct_valid", ct_valid, 0);
    check("rst_tag_valid", tag_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_err_underrun", err_underrun, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_datalen", core_datalen, 0);
    check("rst_blockin", core_blockin, 0);
    check("rst_tag_out", tag_out, 0);

    // Two words ending short: no padding block.
    start_cmd(2'd0);
    push_word(rnd64(), 8, 1'b0);
    push_word(rnd64(), 3, 1'b1);
    check("in_ready_after_last", in_ready, 0);
    core_rd();
    core_rd();
    core_rd_empty();
    check("wait_tag_busy", busy, 1);
    check("no_underrun_after_last", err_underrun, 0);
    send_tag({$urandom, $urandom, $urandom, $urandom});

    // Full final word: a padding read follows; a tag before WAIT_TAG is ignored.
    start_cmd(2'd1);
    push_word(rnd64(), 8, 1'b1);
    core_rd();
    core_Tag = {4{$urandom}};
    core_Tv  = 1'b1;
    tick();
    core_Tv  = 1'b0;
    check("early_tag_ignored", tag_valid, 0);
    check("pad_busy", busy, 1);
    core_rd_empty();
    check("after_pad_busy", busy, 1);
    send_tag({$urandom, $urandom, $urandom, $urandom});

    // Underrun in FEED, then an over-long length clamped to 8.
    start_cmd(2'd2);
    core_rd_empty();
    check("underrun_flag", err_underrun, 1);
    check("underrun_still_feed", in_ready, 1);
    push_word(rnd64(), 15, 1'b1);
    core_rd();
    core_rd_empty();
    check("underrun_sticky", err_underrun, 1);
    send_tag({$urandom, $urandom, $urandom, $urandom});

    // Random messages with interleaved reads.
    for (int m = 0; m < 10; m++) begin
      logic [1:0] mode;
      int nw, len;
      mode = 2'($urandom_range(0, 3));
      start_cmd(mode);
      check("underrun_cleared", err_underrun, 0);
      nw = $urandom_range(1, 7);
      for (int w = 0; w < nw; w++) begin
        if (in_cnt == 4 || (in_cnt > 0 && $urandom_range(0, 2) == 0)) core_rd();
        len = (w == nw - 1 && $urandom_range(0, 1) == 1) ? 8 : $urandom_range(0, 15);
        push_word(rnd64(), len, w == nw - 1);
      end
      while (in_cnt > 0) core_rd();
      if (last_len == 8) core_rd_empty();
      check("mode_held", core_mode, mode);
      send_tag({$urandom, $urandom, $urandom, $urandom});
    end

    // Ciphertext FIFO: overflow, full push+pop, then random traffic.
    check("ovf_clear_before", err_overflow, 0);
    for (int i = 0; i < 5; i++) ct_cycle(1'b1, rnd64(), 1'b0);
    check("ct_held", ct_valid, 1);
    check("ovf_set", err_overflow, 1);
    ct_cycle(1'b1, rnd64(), 1'b1);
    ct_drain();
    check("ovf_sticky", err_overflow, exp_ovf);
    for (int i = 0; i < 60; i++) ct_cycle(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 1)));
    ct_drain();
    check("ovf_model", err_overflow, exp_ovf);

    // Reset in the middle of FEED with words and ciphertext queued.
    start_cmd(2'd3);
    push_word(rnd64(), 8, 1'b0);
    push_word(rnd64(), 8, 1'b0);
    ct_cycle(1'b1, rnd64(), 1'b0);
    nRST = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_ct_valid", ct_valid, 0);
    check("mid_rst_datalen", core_datalen, 0);
    check("mid_rst_mode", core_mode, 0);
    check("mid_rst_tag_out", tag_out, 0);
    nRST = 1'b1;
    core_exp.delete();
    ct_exp.delete();
    ct_model.delete();
    in_cnt  = 0;
    exp_ovf = 1'b0;
    start_cmd(2'd1);
    push_word(rnd64(), 5, 1'b1);
    core_rd();
    send_tag({$urandom, $urandom, $urandom, $urandom});

`ifdef ASCON_TAG_CHECK_EN
    t = 128'h0123456789ABCDEF0123456789ABCDEF;
    exp_tag = t;
    start_cmd(2'd0);
    push_word(rnd64(), 4, 1'b1);
    core_rd();
    send_tag(t);
    check("tag_ok_match", tag_ok, 1);
    start_cmd(2'd0);
    push_word(rnd64(), 4, 1'b1);
    core_rd();
    t[$urandom_range(0, 127)] ^= 1'b1;
    send_tag(t);
    check("tag_ok_mismatch", tag_ok, 0);
`else
    t = '0;
`endif

    tick();
    tick();
    check("core_exp_empty", core_exp.size(), 0);
    check("ct_exp_empty", ct_exp.size(), 0);
    check("tag_exp_empty", tag_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
